// File: rtl/dmi_arbiter.sv
// Round-robin N-master to 1-slave arbiter for the DMI valid/ready channel.
// The granted request is registered toward the slave; an optional timeout forces completion.
module dmi_arbiter #(
  parameter int          N_MASTERS   = 2,
  parameter int          ADDR_W      = 7,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
  localparam int         GW          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS-1:0]        m_valid,
  output logic [N_MASTERS-1:0]        m_ready,
  input  logic [N_MASTERS-1:0]        m_write_en,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        s_valid,
  input  logic                        s_ready,
  output logic                        s_write_en,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic [GW-1:0]               grant_id,
  output logic                        timeout_err
);

  localparam int PW = 1 << GW;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg;
  logic                s_valid_reg;
  logic                s_write_en_reg;
  logic [ADDR_W-1:0]   s_addr_reg;
  logic [DATA_W-1:0]   s_wdata_reg;
  logic [GW-1:0]       grant_id_reg;
  logic [GW-1:0]       last_grant_reg;

  logic [PW-1:0]       valid_pad;
  logic [PW-1:0]       we_pad;
  logic [ADDR_W-1:0]   addr_arr  [PW];
  logic [DATA_W-1:0]   wdata_arr [PW];

  logic                pick_found;
  logic [GW-1:0]       pick_idx;
  logic                busy;
  logic                done_ok;
  logic                done_to;

  // Unpack the master buses into power-of-two sized tables so any grant index is in range.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_unpack
      if (gi < N_MASTERS) begin : g_real
        assign valid_pad[gi] = m_valid[gi];
        assign we_pad[gi]    = m_write_en[gi];
        assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign valid_pad[gi] = 1'b0;
        assign we_pad[gi]    = 1'b0;
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
      end
    end
  endgenerate

  // Search from last_grant+1 upward with wrap; the previous owner is considered last.
  always_comb begin
    logic [GW:0] cand;
    pick_found = 1'b0;
    pick_idx   = last_grant_reg;
    cand       = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = {1'b0, last_grant_reg} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_MASTERS)) begin
        cand = cand - (GW+1)'(N_MASTERS);
      end
      if (!pick_found && valid_pad[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  assign busy    = (state_reg == BUSY);
  assign done_ok = busy && s_ready;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      logic [CW-1:0] cnt_reg;

      // A slave completion in the expiry cycle takes priority over the timeout.
      assign done_to = busy && !s_ready && (cnt_reg == CW'(TIMEOUT_CYC - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (busy && !s_ready && !done_to) begin
          cnt_reg <= cnt_reg + CW'(1);
        end else begin
          cnt_reg <= '0;
        end
      end
    end else begin : g_no_timeout
      assign done_to = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      s_valid_reg    <= 1'b0;
      s_write_en_reg <= 1'b0;
      s_addr_reg     <= '0;
      s_wdata_reg    <= '0;
      grant_id_reg   <= '0;
      last_grant_reg <= GW'(N_MASTERS - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg      <= BUSY;
            s_valid_reg    <= 1'b1;
            s_write_en_reg <= we_pad[pick_idx];
            s_addr_reg     <= addr_arr[pick_idx];
            s_wdata_reg    <= wdata_arr[pick_idx];
            grant_id_reg   <= pick_idx;
            last_grant_reg <= pick_idx;
          end
        end
        BUSY: begin
          if (done_ok || done_to) begin
            state_reg   <= IDLE;
            s_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          s_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_ready
      assign m_ready[gi] = (done_ok || done_to) && (grant_id_reg == GW'(gi));
    end
  endgenerate

  assign m_rdata     = done_ok ? s_rdata : (done_to ? ERR_RDATA : '0);
  assign timeout_err = done_to;
  assign s_valid     = s_valid_reg;
  assign s_write_en  = s_write_en_reg;
  assign s_addr      = s_addr_reg;
  assign s_wdata     = s_wdata_reg;
  assign grant_id    = grant_id_reg;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(m_ready));
  a_timeout_busy : assert property (@(posedge clk) disable iff (!rst_n) timeout_err |-> (busy && !s_ready));

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter: well-behaved masters, a random-latency slave,
// and a transaction-level model predicting grants, completions and timeouts.
module tb_dmi_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int GW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_valid = '0;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    m_write_en = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic            s_ready = 1'b0;
  logic            s_write_en;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata = '0;
  logic [GW-1:0]   grant_id;
  logic            timeout_err;

  always #5 clk = ~clk;

  dmi_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_write_en(m_write_en),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_write_en(s_write_en),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Master-side request state
  bit            pend   [N];
  bit            pwe    [N];
  logic [AW-1:0] paddr  [N];
  logic [DW-1:0] pwdata [N];
  bit            served [N];

  // Reference model: one outstanding transaction, owner, busy-cycle count, captured request
  bit            mdl_busy;
  int            mdl_owner;
  int            mdl_last;
  int            mdl_age;
  bit            mdl_we;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata;

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_owner = 0;
    mdl_last  = N - 1;
    mdl_age   = 0;
    mdl_we    = 1'b0;
    mdl_addr  = '0;
    mdl_wdata = '0;
    for (int i = 0; i < N; i++) served[i] = 1'b0;
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    pwe[i]    = 1'($urandom_range(0, 1));
    paddr[i]  = AW'($urandom);
    pwdata[i] = $urandom;
  endtask

  task automatic apply_masters();
    for (int i = 0; i < N; i++) begin
      m_valid[i]             = pend[i];
      m_write_en[i]          = pwe[i];
      m_addr[i*AW +: AW]     = paddr[i];
      m_wdata[i*DW +: DW]    = pwdata[i];
    end
  endtask

  task automatic run_cycle(input int ready_pct);
    bit            fin_ok;
    bit            fin_to;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_rdata;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (served[i]) begin
        served[i] = 1'b0;
        if ($urandom_range(0, 1) == 0) pend[i] = 1'b0;
        else new_req(i);
      end else if (!pend[i] && $urandom_range(0, 9) < 4) begin
        new_req(i);
      end
    end
    // Disturb the owner's fields mid-transaction; the captured copy must not move.
    if (mdl_busy && pend[mdl_owner] && $urandom_range(0, 3) == 0) begin
      pwdata[mdl_owner] = $urandom;
      paddr[mdl_owner]  = AW'($urandom);
      pwe[mdl_owner]    = ~pwe[mdl_owner];
    end
    apply_masters();
    s_ready = ($urandom_range(0, 99) < ready_pct);
    s_rdata = $urandom;
    #1;
    fin_ok    = mdl_busy && s_ready;
    fin_to    = mdl_busy && !s_ready && (mdl_age + 1 == TO);
    exp_ready = '0;
    if (fin_ok || fin_to) exp_ready[mdl_owner] = 1'b1;
    exp_rdata = fin_ok ? s_rdata : (fin_to ? ERRD : '0);
    check_val("s_valid", 64'(s_valid), 64'(mdl_busy));
    check_val("grant_id", 64'(grant_id), 64'(mdl_owner));
    check_val("s_write_en", 64'(s_write_en), 64'(mdl_we));
    check_val("s_addr", 64'(s_addr), 64'(mdl_addr));
    check_val("s_wdata", 64'(s_wdata), 64'(mdl_wdata));
    check_val("m_ready", 64'(m_ready), 64'(exp_ready));
    check_val("m_rdata", 64'(m_rdata), 64'(exp_rdata));
    check_val("timeout_err", 64'(timeout_err), 64'(fin_to));
    if (fin_ok || fin_to) begin
      n_txn++;
      $display("txn %0d: master %0d %s addr=%h wdata=%h rdata=%h busy_cycles=%0d%s",
               n_txn, mdl_owner, mdl_we ? "WR" : "RD", mdl_addr, mdl_wdata,
               exp_rdata, mdl_age + 1, fin_to ? " timeout" : "");
      served[mdl_owner] = 1'b1;
      mdl_busy = 1'b0;
    end else if (mdl_busy) begin
      mdl_age++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mdl_last + k) % N;
        if (!mdl_busy && pend[i]) begin
          mdl_busy  = 1'b1;
          mdl_owner = i;
          mdl_last  = i;
          mdl_age   = 0;
          mdl_we    = pwe[i];
          mdl_addr  = paddr[i];
          mdl_wdata = pwdata[i];
        end
      end
    end
  endtask

  // Reset pulse placed between clock edges while a transaction is outstanding.
  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    s_ready = 1'b1;
    #1;
    check_val("rst_s_valid", 64'(s_valid), 64'd0);
    check_val("rst_m_ready", 64'(m_ready), 64'd0);
    check_val("rst_m_rdata", 64'(m_rdata), 64'd0);
    check_val("rst_timeout_err", 64'(timeout_err), 64'd0);
    check_val("rst_grant_id", 64'(grant_id), 64'd0);
    check_val("rst_s_addr", 64'(s_addr), 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    $display("reset applied mid-transaction at t=%0t", $time);
  endtask

  initial begin
    int  pct_tab [4];
    bit  reset_armed;
    pct_tab = '{80, 30, 55, 10};
    reset_armed = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_val("init_s_valid", 64'(s_valid), 64'd0);
    check_val("init_s_write_en", 64'(s_write_en), 64'd0);
    check_val("init_s_addr", 64'(s_addr), 64'd0);
    check_val("init_s_wdata", 64'(s_wdata), 64'd0);
    check_val("init_m_ready", 64'(m_ready), 64'd0);
    check_val("init_m_rdata", 64'(m_rdata), 64'd0);
    check_val("init_grant_id", 64'(grant_id), 64'd0);
    check_val("init_timeout_err", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 60) reset_armed = 1'b1;
      if (reset_armed && mdl_busy) begin
        reset_armed = 1'b0;
        reset_mid();
      end
      run_cycle(pct_tab[(c / 50) % 4]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
